// File: rtl/maxpool2d_2x2_stride2_3x_128ch.sv
// rtl/maxpool2d_2x2_stride2_3x_128ch.sv - 2x2 stride-2 max pool of an 8x8x128 nibble map into a 256x32 result memory
// Optional feature: MAXPOOL_CLEAR_ON_RESET_EN zeroes the result memory after reset.
module maxpool2d_2x2_stride2_3x_128ch #(
  parameter int IN_W   = 8,
  parameter int CH     = 128,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] read_addr,
  output logic [3:0]  read_data,
  output logic        done,
  output logic        busy,
  output logic        up_start,
  input  logic        up_done,
  output logic [31:0] up_read_addr,
  input  logic [3:0]  up_read_data
);

  localparam int OUT_W   = IN_W / 2;
  localparam int N_ISSUE = CH * IN_W * IN_W;
  localparam int N_NIB   = CH * OUT_W * OUT_W;
  localparam int N_WORD  = N_NIB / 8;
  localparam int TAG_W   = 14;

  typedef enum logic [2:0] {
    IDLE,
    START_UP,
    WAIT_UP,
    SWEEP,
    DRAIN,
    FINISH,
    CLEAR
  } state_t;

`ifdef MAXPOOL_CLEAR_ON_RESET_EN
  localparam state_t RESET_STATE = CLEAR;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t state, next_state;

  logic [12:0]      cnt;
  logic             issue_go;
  logic [12:0]      issue_idx;
  logic [TAG_W-1:0] iss_tag;
  logic [TAG_W-1:0] tag_pipe [RD_LAT];
  logic             ret_vld, ret_first, ret_last;
  logic [10:0]      ret_out;
  logic [3:0]       run_max, win_max;
  logic [31:0]      pack, pack_next;
  logic             wr_en;
  logic [7:0]       wr_addr;
  logic [31:0]      wr_data;
  logic [31:0]      mem [N_WORD];
  logic             mem_we;
  logic [7:0]       mem_waddr;
  logic [31:0]      mem_wdata;
  logic [31:0]      rd_word;
`ifdef MAXPOOL_CLEAR_ON_RESET_EN
  logic [7:0]       clr_cnt;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= RESET_STATE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = (state != IDLE);
    done       = (state == FINISH);
    up_start   = (state == START_UP);
    case (state)
      IDLE:     if (start) next_state = START_UP;
      START_UP: next_state = WAIT_UP;
      WAIT_UP:  if (up_done) next_state = SWEEP;
      SWEEP:    if (cnt == 13'(N_ISSUE - 1)) next_state = DRAIN;
      DRAIN:    if (wr_en && wr_addr == 8'(N_WORD - 1)) next_state = FINISH;
      FINISH:   next_state = IDLE;
`ifdef MAXPOOL_CLEAR_ON_RESET_EN
      CLEAR:    if (clr_cnt == 8'(N_WORD - 1)) next_state = IDLE;
`else
      CLEAR:    next_state = IDLE;
`endif
      default:  next_state = IDLE;
    endcase
  end

  // Issue index layout: ch[12:6] orow[5:4] ocol[3:2] window quadrant[1:0].
  assign issue_go  = (state == WAIT_UP && up_done) || (state == SWEEP);
  assign issue_idx = (state == SWEEP) ? cnt : 13'd0;

  assign {ret_vld, ret_first, ret_last, ret_out} = tag_pipe[RD_LAT-1];
  assign win_max   = (ret_first || up_read_data > run_max) ? up_read_data : run_max;
  assign pack_next = pack | ({28'd0, win_max} << {~ret_out[2:0], 2'b00});

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt          <= '0;
      up_read_addr <= '0;
      iss_tag      <= '0;
      for (int i = 0; i < RD_LAT; i++) tag_pipe[i] <= '0;
      run_max      <= '0;
      pack         <= '0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
    end else begin
      if (issue_go) begin
        up_read_addr <= {19'd0, issue_idx[12:6], issue_idx[5:4], issue_idx[1],
                         issue_idx[3:2], issue_idx[0]};
        iss_tag      <= {1'b1, issue_idx[1:0] == 2'd0, issue_idx[1:0] == 2'd3,
                         issue_idx[12:2]};
        cnt          <= issue_idx + 13'd1;
      end else begin
        iss_tag <= '0;
      end
      tag_pipe[0] <= iss_tag;
      for (int i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];

      wr_en <= 1'b0;
      if (ret_vld) begin
        run_max <= win_max;
        if (ret_last) begin
          if (ret_out[2:0] == 3'd7) begin
            wr_en   <= 1'b1;
            wr_addr <= ret_out[10:3];
            wr_data <= pack_next;
            pack    <= '0;
          end else begin
            pack <= pack_next;
          end
        end
      end
    end
  end

`ifdef MAXPOOL_CLEAR_ON_RESET_EN
  always_ff @(posedge clk) begin
    if (reset)               clr_cnt <= '0;
    else if (state == CLEAR) clr_cnt <= clr_cnt + 8'd1;
  end
`endif

  // Writes are suppressed on a reset cycle so reset never disturbs stored results.
  always_comb begin
    mem_we    = wr_en & ~reset;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
`ifdef MAXPOOL_CLEAR_ON_RESET_EN
    if (state == CLEAR && !reset) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt;
      mem_wdata = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign rd_word = mem[read_addr[10:3]];

  always_ff @(posedge clk) begin
    if (reset)                         read_data <= '0;
    else if (read_addr >= 32'(N_NIB))  read_data <= '0;
    else                               read_data <= rd_word[{~read_addr[2:0], 2'b00} +: 4];
  end

endmodule
